// File: rtl/lsu_mem_if_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_mem_if_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: takes one decoder-issued load or store, runs a
// req/gnt/rvalid transaction on the data bus, aligns/extends load data and
// returns it as a one-cycle delayed_load/delayed_rd write-back.
module lsu_mem_if #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        size_i,
  input  logic [4:0]        rd_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  lsu_mem_if_if.master      bus,
  output logic              delayed_load,
  output logic [4:0]        delayed_rd,
  output logic [31:0]       load_data,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // What survives from the issue cycle until write-back.
  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [4:0] rd;
    logic [1:0] off;
  } req_t;

  state_t        state;
  req_t          req_q;
  logic [31:0]   rdata_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          issue, size_ok, misalign, legal;
  logic [3:0]    lane_strb;
  logic [31:0]   lane_data;
  logic [31:0]   sh, ext;
  logic          tmo;

  assign cnt_inc = cnt + 1'b1;
  assign tmo     = (cnt_inc == CW'(TIMEOUT));

  // Issue decode: sizes 101..111 are illegal; halves need addr[0]=0, words addr[1:0]=0.
  always_comb begin
    issue    = load_i | store_i;
    size_ok  = (size_i <= 3'b100);
    misalign = ((size_i[2:1] == 2'b01) && addr_i[0]) ||
               ((size_i == 3'b100) && (addr_i[1:0] != 2'b00));
    legal    = issue && size_ok && !misalign;
    busy_o   = ((state == IDLE) && legal) || (state == REQ) || (state == WAIT);
  end

  // Store lane placement: strobes start at the byte offset, data replicated across lanes.
  always_comb begin
    lane_strb = 4'b1111;
    lane_data = wdata_i;
    case (size_i[2:1])
      2'b00: begin
        lane_strb = 4'b0001 << addr_i[1:0];
        lane_data = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << addr_i[1:0];
        lane_data = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: shift the addressed byte/half down, then sign/zero extend.
  always_comb begin
    sh = rdata_q >> {req_q.off, 3'b000};
    case (req_q.size)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {24'd0, sh[7:0]};
      3'b010:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b011:  ext = {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  // Transaction FSM with registered bus and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_q         <= '0;
      rdata_q       <= '0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
      delayed_load  <= 1'b0;
      delayed_rd    <= '0;
      load_data     <= '0;
      err_o         <= 1'b0;
    end else begin
      err_o        <= 1'b0;
      delayed_load <= 1'b0;
      case (state)
        IDLE: begin
          if (issue && !legal) begin
            err_o <= 1'b1;
          end else if (legal) begin
            // load wins when both strobes are high
            req_q         <= '{we: !load_i, size: size_i, rd: rd_i, off: addr_i[1:0]};
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= !load_i;
            bus.mem_addr  <= {addr_i[31:2], 2'b00};
            bus.mem_wstrb <= load_i ? 4'b0000 : lane_strb;
            bus.mem_wdata <= load_i ? 32'd0 : lane_data;
            cnt           <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (req_q.we) begin
              state <= IDLE;
            end else if (bus.mem_rvalid) begin
              rdata_q <= bus.mem_rdata;
              state   <= DONE;
            end else begin
              cnt   <= '0;
              state <= WAIT;
            end
          end else if (tmo) begin
            bus.mem_req <= 1'b0;
            err_o       <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            rdata_q <= bus.mem_rdata;
            state   <= DONE;
          end else if (tmo) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          // load_data updates together with the strobe and holds until the next load
          delayed_load <= 1'b1;
          delayed_rd   <= req_q.rd;
          load_data    <= ext;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: a per-cycle stimulus table plus a timeline model of
// expected outputs, built from transaction-level plans; one compare process
// checks every cycle, with a few literal pins on known cycles.
module tb_lsu_mem_if;
  localparam int N = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_i = 0, store_i = 0;
  logic [2:0]  size_i = 0;
  logic [4:0]  rd_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0;
  logic        delayed_load, busy_o, err_o;
  logic [4:0]  delayed_rd;
  logic [31:0] load_data;

  lsu_mem_if_if bus();

  lsu_mem_if #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .load_i(load_i), .store_i(store_i), .size_i(size_i), .rd_i(rd_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .bus(bus),
    .delayed_load(delayed_load), .delayed_rd(delayed_rd), .load_data(load_data),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, load, store;
    logic [2:0]  size;
    logic [4:0]  rd;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
  } stim_t;

  stim_t       stim [N];
  bit          exp_req [N], exp_busy [N], exp_dl [N], exp_err [N], exp_we [N];
  logic [31:0] exp_addr [N], exp_wdata [N], exp_data [N];
  logic [3:0]  exp_strb [N];
  logic [4:0]  exp_rd [N];

  int errors = 0, checks = 0;
  int cyc = -1;
  logic [31:0] held = 0;

  task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  // Load result from plain arithmetic on the bus word.
  function automatic logic [31:0] ld_expect(logic [31:0] w, logic [31:0] a, logic [2:0] sz);
    int o = int'(a[1:0]);
    longint v;
    case (sz)
      3'b000, 3'b001: begin
        v = longint'((w >> (8 * o)) & 32'hFF);
        if (sz == 3'b000 && v >= 128) v = v - 256;
      end
      3'b010, 3'b011: begin
        v = longint'((w >> (8 * o)) & 32'hFFFF);
        if (sz == 3'b010 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // t: issue cycle, g: cycles before grant, r: cycles from grant to rvalid
  // (-1 = never, timeout expected; -2 = aborted by reset, caller handles it)
  task automatic plan_load(int t, logic [2:0] sz, logic [31:0] a, logic [4:0] rd,
                           int g, int r, logic [31:0] w, bit both);
    int gc = t + 1 + g;
    stim[t].load = 1; stim[t].store = both; stim[t].size = sz; stim[t].rd = rd;
    stim[t].addr = a; stim[t].wdata = both ? 32'hFFFF_FFFF : 32'd0;
    for (int c = t + 1; c <= gc; c++) begin
      exp_req[c] = 1; exp_addr[c] = {a[31:2], 2'b00};
      exp_we[c] = 0; exp_strb[c] = 0; exp_wdata[c] = 0;
    end
    stim[gc].gnt = 1;
    if (r >= 0) begin
      stim[gc + r].rvalid = 1; stim[gc + r].rdata = w;
      for (int c = t; c <= gc + r; c++) exp_busy[c] = 1;
      exp_dl[gc + r + 2] = 1; exp_rd[gc + r + 2] = rd;
      exp_data[gc + r + 2] = ld_expect(w, a, sz);
    end else if (r == -1) begin
      for (int c = t; c <= gc + 16; c++) exp_busy[c] = 1;
      exp_err[gc + 17] = 1;
    end else begin
      for (int c = t; c <= gc + 1; c++) exp_busy[c] = 1;
    end
  endtask

  // g = -1: never granted, request times out after 16 cycles
  task automatic plan_store(int t, logic [2:0] sz, logic [31:0] a, logic [31:0] wd, int g);
    int nb = (sz[2:1] == 2'b00) ? 1 : (sz[2:1] == 2'b01) ? 2 : 4;
    int o = (nb == 4) ? 0 : int'(a[1:0]);
    int last = (g < 0) ? t + 16 : t + 1 + g;
    logic [3:0]  s;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      s[i] = (i >= o) && (i < o + nb);
      d[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    stim[t].store = 1; stim[t].size = sz; stim[t].addr = a; stim[t].wdata = wd;
    for (int c = t + 1; c <= last; c++) begin
      exp_req[c] = 1; exp_addr[c] = {a[31:2], 2'b00};
      exp_we[c] = 1; exp_strb[c] = s; exp_wdata[c] = d;
    end
    for (int c = t; c <= last; c++) exp_busy[c] = 1;
    if (g < 0) exp_err[last + 1] = 1;
    else stim[last].gnt = 1;
  endtask

  task automatic plan_illegal(int t, logic [2:0] sz, logic [31:0] a);
    stim[t].load = 1; stim[t].size = sz; stim[t].addr = a;
    exp_err[t + 1] = 1;
  endtask

  // Per-cycle comparison against the timeline model plus literal pins.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      if (stim[cyc].rst) begin
        held = 0;
        chk("rst_rd", cyc, 32'(delayed_rd), 32'd0);
        chk("rst_addr", cyc, bus.mem_addr, 32'd0);
      end
      if (exp_dl[cyc]) held = exp_data[cyc];
      chk("mem_req", cyc, 32'(bus.mem_req), 32'(exp_req[cyc]));
      chk("busy_o", cyc, 32'(busy_o), 32'(exp_busy[cyc]));
      chk("err_o", cyc, 32'(err_o), 32'(exp_err[cyc]));
      chk("delayed_load", cyc, 32'(delayed_load), 32'(exp_dl[cyc]));
      chk("load_data", cyc, load_data, held);
      if (exp_dl[cyc]) chk("delayed_rd", cyc, 32'(delayed_rd), 32'(exp_rd[cyc]));
      if (exp_req[cyc]) begin
        chk("mem_addr", cyc, bus.mem_addr, exp_addr[cyc]);
        chk("mem_we", cyc, 32'(bus.mem_we), 32'(exp_we[cyc]));
        chk("mem_wstrb", cyc, 32'(bus.mem_wstrb), 32'(exp_strb[cyc]));
        chk("mem_wdata", cyc, bus.mem_wdata, exp_wdata[cyc]);
      end
      case (cyc)
        5:  chk("pin_addr_1000", cyc, bus.mem_addr, 32'h0000_1000);
        7:  begin
              chk("pin_lb", cyc, load_data, 32'hFFFF_FF80);
              chk("pin_rd5", cyc, 32'(delayed_rd), 32'd5);
            end
        12: chk("pin_lbu", cyc, load_data, 32'h0000_0080);
        16: begin
              chk("pin_sh_strb", cyc, 32'(bus.mem_wstrb), 32'hC);
              chk("pin_sh_data", cyc, bus.mem_wdata, 32'hABCD_ABCD);
            end
        22, 25, 46, 94, 97: chk("pin_err", cyc, 32'(err_o), 32'd1);
        53: chk("pin_rst_req", cyc, 32'(bus.mem_req), 32'd0);
        58: chk("pin_both_we", cyc, 32'({bus.mem_we, bus.mem_wstrb}), 32'd0);
        69: chk("pin_lh", cyc, load_data, 32'hFFFF_8001);
        default: ;
      endcase
    end
  end

  initial begin
    for (int i = 0; i < N; i++) stim[i] = '0;
    stim[0].rst = 1; stim[1].rst = 1;
    plan_load(4, 3'b000, 32'h1003, 5'd5, 0, 0, 32'h80FF_FFFF, 0);
    plan_load(9, 3'b001, 32'h1003, 5'd6, 0, 0, 32'h80FF_FFFF, 0);
    plan_store(14, 3'b010, 32'h2002, 32'h1234_ABCD, 3);
    stim[16].load = 1; stim[16].size = 3'b100; stim[16].addr = 32'h40; // ignored while busy
    plan_illegal(21, 3'b100, 32'h2001);
    plan_illegal(24, 3'b110, 32'h40);
    plan_load(27, 3'b100, 32'h300, 5'd9, 1, -1, 32'd0, 0);
    stim[48].rvalid = 1; stim[48].rdata = 32'h1234_5678; // late, must be ignored
    plan_load(50, 3'b100, 32'h500, 5'd3, 0, -2, 32'd0, 0);
    stim[53].rst = 1; stim[54].rst = 1;
    stim[53].rvalid = 1; stim[53].rdata = 32'h7777_7777;
    plan_load(57, 3'b100, 32'h40, 5'd7, 0, 2, 32'hDEAD_BEEF, 1);
    plan_load(64, 3'b010, 32'h2, 5'd0, 2, 0, 32'h8001_0000, 0);
    plan_store(71, 3'b000, 32'h1001, 32'h0000_0055, 0);
    plan_store(74, 3'b100, 32'h100, 32'hCAFE_F00D, 0);
    plan_store(77, 3'b100, 32'h104, 32'h0BAD_0BAD, -1);
    plan_illegal(96, 3'b011, 32'h3);

    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rst            = stim[c].rst;
      load_i         = stim[c].load;
      store_i        = stim[c].store;
      size_i         = stim[c].size;
      rd_i           = stim[c].rd;
      addr_i         = stim[c].addr;
      wdata_i        = stim[c].wdata;
      bus.mem_gnt    = stim[c].gnt;
      bus.mem_rvalid = stim[c].rvalid;
      bus.mem_rdata  = stim[c].rdata;
      cyc            = c;
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit that sits between the decoder's memory controls and the data-memory bus.
- Accepts one load or store per issue from the decoder (load strobe, store enable, size code, rd, ALU address, rs2 data).
- Runs a request/grant/response transaction on the data bus, aligns and extends load data, and returns the write-back as the delayed_load / delayed_rd pair the decoder consumes.
- Holds the pipeline stall while a transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum cycles waiting for grant or read response before aborting with err_o; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- load_i  in  1  load issue strobe from decoder
- store_i  in  1  store issue strobe from decoder
- size_i  in  3  access size: 000 byte, 001 byte unsigned, 010 half, 011 half unsigned, 100 word
- rd_i  in  5  load destination register
- addr_i  in  32  effective address from ALU
- wdata_i  in  32  store data (rs2)
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wstrb  out  4  byte-lane write strobes
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus grant (request accepted this cycle)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- delayed_load  out  1  one-cycle write-back strobe for a completed load
- delayed_rd  out  5  write-back register, valid with delayed_load
- load_data  out  32  aligned, extended load result, valid with delayed_load
- busy_o  out  1  stall request to pipeline
- err_o  out  1  one-cycle pulse: misaligned, illegal size, or timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; captured registers 0.
- Reset asserted mid-transaction: mem_req drops immediately (async); no delayed_load or err_o is produced for the aborted access.

FSM states: IDLE, REQ, WAIT, DONE.

IDLE
- On load_i or store_i: capture addr, size, rd, wdata, and direction. If both strobes are high, load wins.
- Illegal size (101–111), half with addr[0]=1, or word with addr[1:0]!=0: err_o pulses next cycle, no bus access, stay in IDLE.
- Otherwise go to REQ next cycle.
- busy_o is combinationally high when a legal issue is present in IDLE, and high in REQ and WAIT. It is low in DONE and IDLE otherwise.
- Strobes arriving while not in IDLE are ignored; the core is stalled then.

REQ
- mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata held stable until mem_gnt.
- Store + gnt: go to IDLE; completes with no delayed_load.
- Load + gnt + rvalid in the same cycle: capture rdata, go to DONE.
- Load + gnt without rvalid: go to WAIT.

WAIT
- mem_req=0.
- On mem_rvalid: capture rdata, go to DONE.

DONE
- delayed_load=1 and delayed_rd=captured rd for exactly one cycle, with load_data valid; then go to IDLE.
- rd=0 loads still complete the access and pulse delayed_load with delayed_rd=0.

Timeout
- A cycle counter clears on entry to REQ and on entry to WAIT.
- When it reaches TIMEOUT in REQ or WAIT: err_o pulses, go to IDLE, mem_req drops, no delayed_load.
- mem_rvalid outside WAIT/REQ is ignored.

Store lanes, with o=addr[1:0]
- byte: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}
- half: wstrb=4'b0011<<o, wdata={2{wdata[15:0]}}
- word: wstrb=4'b1111, wdata=wdata
- mem_wstrb=0 and mem_wdata=0 for loads.

Load extraction
- s = mem_rdata >> (8*o).
- Byte: sign- or zero-extend s[7:0] per size code. Half: likewise for s[15:0]. Word: s.
- load_data is held after DONE until the next load's DONE.

Latency
- Zero-wait bus: load issue → delayed_load 3 cycles later (IDLE→REQ→DONE→pulse); store issue → bus write 1 cycle later.

Test Plan:
- Byte load, addr_i=0x1003, size 000, rd=5, gnt+rvalid same cycle, rdata=0x80FFFFFF → mem_addr=0x1000; delayed_load one cycle with delayed_rd=5, load_data=0xFFFFFF80; with size 001 → 0x00000080.
- Half store, addr_i=0x2002, wdata_i=0x1234ABCD, gnt delayed 3 cycles → mem_req held 4 cycles with mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1; busy_o high throughout; no delayed_load.
- Word load at 0x2001 → err_o pulses once, mem_req never asserts; size 110 at aligned address → same.
- Load granted, rvalid withheld past TIMEOUT=16 → err_o pulses 16 cycles after entering WAIT, return to IDLE; a late rvalid afterwards produces nothing.
- rst raised while in WAIT, then rvalid arrives → mem_req=0 and delayed_load=0 immediately; no write-back after release.
- load_i and store_i both high, size 100, addr 0x40 → treated as a load: mem_we=0, mem_wstrb=0000.
